// File: rtl/obi_arb_pkg.sv
// Shared types for the OBI round-robin arbiter and its ID FIFO.
// Index and count types are sized for the largest legal configuration (8 managers, 8 outstanding).
package obi_arb_pkg;

   localparam int unsigned MaxNumMgr        = 8;
   localparam int unsigned MaxOutstandingLm = 8;
   localparam int unsigned DefDataWidth     = 32;
   localparam int unsigned BeWidth          = DefDataWidth / 8;

   localparam int unsigned MgrIdxWidth  = (MaxNumMgr > 1) ? $clog2(MaxNumMgr) : 1;
   localparam int unsigned FifoCntWidth = $clog2(MaxOutstandingLm + 1);

   typedef logic [MgrIdxWidth-1:0]  mgr_idx_t;
   typedef logic [FifoCntWidth-1:0] fifo_cnt_t;

   // Successor index modulo n.
   function automatic mgr_idx_t next_idx(input mgr_idx_t idx, input int unsigned n);
      if (32'(idx) + 32'd1 >= n) begin
         return '0;
      end
      return idx + mgr_idx_t'(1);
   endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// FIFO of granted manager indices, one entry per outstanding OBI transaction.
// A pop in the same cycle frees a slot for a push even when full.
module obi_arb_id_fifo
   import obi_arb_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      push_i,
   input  mgr_idx_t  data_i,
   input  logic      pop_i,
   output mgr_idx_t  head_o,
   output fifo_cnt_t count_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   typedef logic [PtrWidth-1:0] ptr_t;

   mgr_idx_t  mem_q [Depth];
   ptr_t      wptr_q, wptr_d;
   ptr_t      rptr_q, rptr_d;
   fifo_cnt_t cnt_q, cnt_d;
   logic      do_push, do_pop;

   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   assign full_o  = (cnt_q == fifo_cnt_t'(Depth));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rptr_q];

   always_comb begin
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
      wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
      rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
      cnt_d   = cnt_q + fifo_cnt_t'(do_push) - fifo_cnt_t'(do_pop);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (do_push) begin
            mem_q[wptr_q] <= data_i;
         end
      end
   end

endmodule

// File: rtl/obi_rr_arbiter.sv
// N-to-1 OBI arbiter with response routing by a FIFO of granted manager indices.
// Define OBI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module obi_rr_arbiter
   import obi_arb_pkg::*;
#(
   parameter int unsigned NumMgr         = 2,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddrWidth      = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumMgr-1:0]             mgr_req_i,
   output logic [NumMgr-1:0]             mgr_gnt_o,
   input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
   input  logic [NumMgr-1:0]             mgr_we_i,
   input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
   input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
   output logic [NumMgr-1:0]             mgr_rvalid_o,
   output logic [NumMgr*DataWidth-1:0]   mgr_rdata_o,
   output logic                          sbr_req_o,
   input  logic                          sbr_gnt_i,
   output logic [AddrWidth-1:0]          sbr_addr_o,
   output logic                          sbr_we_o,
   output logic [DataWidth/8-1:0]        sbr_be_o,
   output logic [DataWidth-1:0]          sbr_wdata_o,
   input  logic                          sbr_rvalid_i,
   input  logic [DataWidth-1:0]          sbr_rdata_i,
   output logic                          err_o
);

   localparam int unsigned BeW = DataWidth / 8;

   mgr_idx_t  rr_q, rr_d;
   mgr_idx_t  sel_q, sel_d;
   logic      lock_q, lock_d;
   logic      err_q, err_d;

   mgr_idx_t  cand, sel, hi_idx, lo_idx;
   logic      hi_found, lo_found;
   logic      sel_req, can_issue, hs;

   mgr_idx_t  fifo_head;
   fifo_cnt_t fifo_count;
   logic      fifo_full, fifo_empty, fifo_pop;

   // hi_* is the first requester at or above rr_q; lo_* is the first requester overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int unsigned i = 0; i < NumMgr; i++) begin
         if (mgr_req_i[i]) begin
            if (!hi_found && (32'(rr_q) <= i)) begin
               hi_found = 1'b1;
               hi_idx   = mgr_idx_t'(i);
            end
            if (!lo_found) begin
               lo_found = 1'b1;
               lo_idx   = mgr_idx_t'(i);
            end
         end
      end
`ifdef OBI_ARB_FIXED_PRIO_EN
      cand = lo_idx;
`else
      cand = hi_found ? hi_idx : lo_idx;
`endif
   end

   assign sel = lock_q ? sel_q : cand;

   always_comb begin
      sel_req     = 1'b0;
      sbr_addr_o  = '0;
      sbr_we_o    = 1'b0;
      sbr_be_o    = '0;
      sbr_wdata_o = '0;
      for (int unsigned i = 0; i < NumMgr; i++) begin
         if (sel == mgr_idx_t'(i)) begin
            sel_req     = mgr_req_i[i];
            sbr_addr_o  = mgr_addr_i[i*AddrWidth +: AddrWidth];
            sbr_we_o    = mgr_we_i[i];
            sbr_be_o    = mgr_be_i[i*BeW +: BeW];
            sbr_wdata_o = mgr_wdata_i[i*DataWidth +: DataWidth];
         end
      end
   end

   // A response popping this cycle frees the slot the new request needs.
   assign fifo_pop  = sbr_rvalid_i & ~fifo_empty;
   assign can_issue = ~fifo_full | (sbr_rvalid_i & (fifo_count != '0));
   assign sbr_req_o = rst_ni & sel_req & can_issue;
   assign hs        = sbr_req_o & sbr_gnt_i;

   always_comb begin
      for (int unsigned i = 0; i < NumMgr; i++) begin
         mgr_gnt_o[i]    = hs & (sel == mgr_idx_t'(i));
         mgr_rvalid_o[i] = rst_ni & fifo_pop & (fifo_head == mgr_idx_t'(i));
      end
   end

   assign mgr_rdata_o = {NumMgr{sbr_rdata_i}};
   assign err_o       = err_q;

   always_comb begin
      rr_d   = rr_q;
      sel_d  = sel_q;
      lock_d = lock_q;
      err_d  = err_q | (sbr_rvalid_i & fifo_empty);
      if (hs) begin
         lock_d = 1'b0;
`ifdef OBI_ARB_FIXED_PRIO_EN
         rr_d   = '0;
`else
         rr_d   = next_idx(sel, NumMgr);
`endif
      end else if (sbr_req_o) begin
         lock_d = 1'b1;
         sel_d  = sel;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q   <= '0;
         sel_q  <= '0;
         lock_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         rr_q   <= rr_d;
         sel_q  <= sel_d;
         lock_q <= lock_d;
         err_q  <= err_d;
      end
   end

   obi_arb_id_fifo #(
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (hs),
      .data_i  (sel),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter: 2 managers, 2 outstanding, downstream driven by hand.
module tb_obi_rr_arbiter;

   localparam int unsigned NumMgr = 2;
   localparam int unsigned MaxOut = 2;
   localparam int unsigned DW     = 32;
   localparam int unsigned AW     = 32;

   logic                   clk_i = 1'b0;
   logic                   rst_ni = 1'b0;
   logic [NumMgr-1:0]      mgr_req_i = '0;
   logic [NumMgr-1:0]      mgr_gnt_o;
   logic [NumMgr*AW-1:0]   mgr_addr_i = {32'h0000_0200, 32'h0000_0100};
   logic [NumMgr-1:0]      mgr_we_i = 2'b10;
   logic [NumMgr*DW/8-1:0] mgr_be_i = 8'hF3;
   logic [NumMgr*DW-1:0]   mgr_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
   logic [NumMgr-1:0]      mgr_rvalid_o;
   logic [NumMgr*DW-1:0]   mgr_rdata_o;
   logic                   sbr_req_o;
   logic                   sbr_gnt_i = 1'b0;
   logic [AW-1:0]          sbr_addr_o;
   logic                   sbr_we_o;
   logic [DW/8-1:0]        sbr_be_o;
   logic [DW-1:0]          sbr_wdata_o;
   logic                   sbr_rvalid_i = 1'b0;
   logic [DW-1:0]          sbr_rdata_i = '0;
   logic                   err_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_i = ~clk_i;

   obi_rr_arbiter #(
      .NumMgr         (NumMgr),
      .MaxOutstanding (MaxOut),
      .DataWidth      (DW),
      .AddrWidth      (AW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .mgr_req_i    (mgr_req_i),
      .mgr_gnt_o    (mgr_gnt_o),
      .mgr_addr_i   (mgr_addr_i),
      .mgr_we_i     (mgr_we_i),
      .mgr_be_i     (mgr_be_i),
      .mgr_wdata_i  (mgr_wdata_i),
      .mgr_rvalid_o (mgr_rvalid_o),
      .mgr_rdata_o  (mgr_rdata_o),
      .sbr_req_o    (sbr_req_o),
      .sbr_gnt_i    (sbr_gnt_i),
      .sbr_addr_o   (sbr_addr_o),
      .sbr_we_o     (sbr_we_o),
      .sbr_be_o     (sbr_be_o),
      .sbr_wdata_o  (sbr_wdata_o),
      .sbr_rvalid_i (sbr_rvalid_i),
      .sbr_rdata_i  (sbr_rdata_i),
      .err_o        (err_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Apply one cycle of stimulus just after the edge, then settle before checking.
   task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                        input logic [31:0] rd);
      @(posedge clk_i);
      #1;
      mgr_req_i    = req;
      sbr_gnt_i    = gnt;
      sbr_rvalid_i = rv;
      sbr_rdata_i  = rd;
      #1;
   endtask

   initial begin
      mgr_req_i = 2'b11;
      sbr_gnt_i = 1'b1;
      #2;
      check("rst_gnt", 64'(mgr_gnt_o), 64'h0);
      check("rst_req", 64'(sbr_req_o), 64'h0);
      check("rst_rvalid", 64'(mgr_rvalid_o), 64'h0);
      check("rst_err", 64'(err_o), 64'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      mgr_req_i = '0;

      // Two continuous requesters, 1-cycle responses.
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      check("alt0_gnt", 64'(mgr_gnt_o), 64'h1);
      check("alt0_addr", 64'(sbr_addr_o), 64'h100);
      check("alt0_wdata", 64'(sbr_wdata_o), 64'hAAAA_0000);
      drive(2'b11, 1'b1, 1'b1, 32'hA0);
      check("alt1_gnt", 64'(mgr_gnt_o), 64'h2);
      check("alt1_addr", 64'(sbr_addr_o), 64'h200);
      check("alt1_we", 64'(sbr_we_o), 64'h1);
      check("alt1_rvalid", 64'(mgr_rvalid_o), 64'h1);
      check("alt1_rdata", 64'(mgr_rdata_o[31:0]), 64'hA0);
      drive(2'b11, 1'b1, 1'b1, 32'hA1);
      check("alt2_gnt", 64'(mgr_gnt_o), 64'h1);
      check("alt2_rvalid", 64'(mgr_rvalid_o), 64'h2);
      check("alt2_rdata", 64'(mgr_rdata_o[63:32]), 64'hA1);
      drive(2'b11, 1'b1, 1'b1, 32'hA2);
      check("alt3_gnt", 64'(mgr_gnt_o), 64'h2);
      check("alt3_rvalid", 64'(mgr_rvalid_o), 64'h1);
      drive(2'b00, 1'b1, 1'b1, 32'hA3);
      check("alt4_rvalid", 64'(mgr_rvalid_o), 64'h2);
      check("alt4_req", 64'(sbr_req_o), 64'h0);

      // Lone requester gets back-to-back grants.
      drive(2'b10, 1'b1, 1'b0, 32'h0);
      check("solo_gnt0", 64'(mgr_gnt_o), 64'h2);
      for (int i = 1; i < 4; i++) begin
         drive(2'b10, 1'b1, 1'b1, 32'hB0 + 32'(i));
         check("solo_gnt", 64'(mgr_gnt_o), 64'h2);
         check("solo_rvalid", 64'(mgr_rvalid_o), 64'h2);
      end
      drive(2'b00, 1'b1, 1'b1, 32'hB4);
      check("solo_last_rvalid", 64'(mgr_rvalid_o), 64'h2);
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      check("rr_wrapped_to_0", 64'(mgr_gnt_o), 64'h1);
      drive(2'b00, 1'b1, 1'b1, 32'hC0);
      check("rr_wrap_rvalid", 64'(mgr_rvalid_o), 64'h1);

      // Downstream stall holds the selection although mgr1 now has priority.
      drive(2'b01, 1'b0, 1'b0, 32'h0);
      check("lock0_req", 64'(sbr_req_o), 64'h1);
      check("lock0_gnt", 64'(mgr_gnt_o), 64'h0);
      check("lock0_addr", 64'(sbr_addr_o), 64'h100);
      drive(2'b11, 1'b0, 1'b0, 32'h0);
      check("lock1_addr", 64'(sbr_addr_o), 64'h100);
      check("lock1_gnt", 64'(mgr_gnt_o), 64'h0);
      drive(2'b11, 1'b0, 1'b0, 32'h0);
      check("lock2_addr", 64'(sbr_addr_o), 64'h100);
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      check("lock_rel_gnt", 64'(mgr_gnt_o), 64'h1);
      check("lock_rel_addr", 64'(sbr_addr_o), 64'h100);
      drive(2'b10, 1'b1, 1'b1, 32'hD0);
      check("lock_next_gnt", 64'(mgr_gnt_o), 64'h2);
      check("lock_next_addr", 64'(sbr_addr_o), 64'h200);
      check("lock_next_rvalid", 64'(mgr_rvalid_o), 64'h1);
      drive(2'b00, 1'b1, 1'b1, 32'hD1);
      check("lock_drain_rvalid", 64'(mgr_rvalid_o), 64'h2);

      // Outstanding limit blocks the third request until a response frees a slot.
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      check("out0_gnt", 64'(mgr_gnt_o), 64'h1);
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      check("out1_gnt", 64'(mgr_gnt_o), 64'h2);
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      check("out_full_req", 64'(sbr_req_o), 64'h0);
      check("out_full_gnt", 64'(mgr_gnt_o), 64'h0);
      drive(2'b11, 1'b1, 1'b1, 32'hE0);
      check("out_pop_req", 64'(sbr_req_o), 64'h1);
      check("out_pop_gnt", 64'(mgr_gnt_o), 64'h1);
      check("out_pop_rvalid", 64'(mgr_rvalid_o), 64'h1);
      drive(2'b00, 1'b1, 1'b1, 32'hE1);
      check("out_drain1", 64'(mgr_rvalid_o), 64'h2);
      drive(2'b00, 1'b1, 1'b1, 32'hE2);
      check("out_drain2", 64'(mgr_rvalid_o), 64'h1);

      // Spurious response with nothing outstanding.
      drive(2'b00, 1'b1, 1'b1, 32'hF0);
      check("spur_rvalid", 64'(mgr_rvalid_o), 64'h0);
      check("spur_err_pre", 64'(err_o), 64'h0);
      for (int i = 0; i < 3; i++) begin
         drive(2'b00, 1'b1, 1'b0, 32'h0);
         check("spur_err_sticky", 64'(err_o), 64'h1);
      end

      // Reset with one transaction outstanding, then a late response.
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      check("mid_gnt", 64'(mgr_gnt_o), 64'h1);
      @(posedge clk_i);
      #1;
      rst_ni       = 1'b0;
      mgr_req_i    = 2'b11;
      sbr_rvalid_i = 1'b1;
      #1;
      check("mid_rst_gnt", 64'(mgr_gnt_o), 64'h0);
      check("mid_rst_req", 64'(sbr_req_o), 64'h0);
      check("mid_rst_rvalid", 64'(mgr_rvalid_o), 64'h0);
      check("mid_rst_err", 64'(err_o), 64'h0);
      @(posedge clk_i);
      #1;
      rst_ni       = 1'b1;
      mgr_req_i    = 2'b00;
      sbr_rvalid_i = 1'b1;
      #1;
      check("late_rvalid", 64'(mgr_rvalid_o), 64'h0);
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      check("late_err", 64'(err_o), 64'h1);
      check("post_rst_rr", 64'(mgr_gnt_o), 64'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
